// File: rtl/uart_pkg.sv
// Shared UART framing definitions: word tags, payload layout, TX FSM states and word builders.
// Used by the transmit scheduler and by the receive-side demultiplexer.
package uart_pkg;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PAYLOAD_W = 12;
  localparam int unsigned WORD_W    = TAG_W + PAYLOAD_W;
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned IDX_W     = 3;

  localparam logic [TAG_W-1:0] TAG_BALL_X = 4'h1;
  localparam logic [TAG_W-1:0] TAG_BALL_Y = 4'h2;
  localparam logic [TAG_W-1:0] TAG_PL_X   = 4'h3;
  localparam logic [TAG_W-1:0] TAG_PL_Y   = 4'h4;
  localparam logic [TAG_W-1:0] TAG_SCORE  = 4'h5;
  localparam logic [TAG_W-1:0] TAG_TOUCH  = 4'h6;
  localparam logic [TAG_W-1:0] TAG_EVENT  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } uart_word_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] ball_posx;
    logic [PAYLOAD_W-1:0] ball_posy;
    logic [PAYLOAD_W-1:0] pl_posx;
    logic [PAYLOAD_W-1:0] pl_posy;
    logic [SCORE_W-1:0]   score_pl1;
    logic [SCORE_W-1:0]   score_pl2;
    logic                 last_touch;
  } state_snap_t;

  // State word for a given frame index; out-of-range indices yield an all-zero word.
  function automatic uart_word_t state_word(input state_snap_t s, input logic [IDX_W-1:0] idx);
    uart_word_t w;
    w = '0;
    case (idx)
      3'd0:    w = '{tag: TAG_BALL_X, payload: s.ball_posx};
      3'd1:    w = '{tag: TAG_BALL_Y, payload: s.ball_posy};
      3'd2:    w = '{tag: TAG_PL_X,   payload: s.pl_posx};
      3'd3:    w = '{tag: TAG_PL_Y,   payload: s.pl_posy};
      3'd4:    w = '{tag: TAG_SCORE,  payload: {4'b0, s.score_pl1, s.score_pl2}};
      3'd5:    w = '{tag: TAG_TOUCH,  payload: {11'b0, s.last_touch}};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic uart_word_t event_word(input logic endgame, input logic whistle);
    return '{tag: TAG_EVENT, payload: {10'b0, endgame, whistle}};
  endfunction

endpackage

// File: rtl/uart_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags the TIMEOUT_CYCLES-th one.
// expired is combinational so the owner can act on it in the same cycle.
module uart_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = enable && (cnt_q == LAST_CNT);

  // Saturates at the terminal count until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Schedules snapshotted game-state frames and sticky event words onto a 16-bit serializer,
// one word in flight at a time, with a tx_done watchdog.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65000,
  parameter int unsigned FRAME_WORDS    = 6
) (
  input  logic                 clk65MHz,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [PAYLOAD_W-1:0] ball_posx,
  input  logic [PAYLOAD_W-1:0] ball_posy,
  input  logic [PAYLOAD_W-1:0] pl_posx,
  input  logic [PAYLOAD_W-1:0] pl_posy,
  input  logic [SCORE_W-1:0]   score_pl1,
  input  logic [SCORE_W-1:0]   score_pl2,
  input  logic                 last_touch,
  input  logic                 whistle_req,
  input  logic                 endgame_req,
  input  logic                 conv16to8ready,
  input  logic                 tx_done,
  output logic [WORD_W-1:0]    data,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  tx_state_e      state_q, state_d;
  uart_word_t     data_q, data_d;
  state_snap_t    snap_q, snap_d, live_snap;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]     pend_q, pend_d, pend_now, req;
  logic           frame_q, frame_d;
  logic           evt_q, evt_d;
  logic           dv_d, busy_d, ov_d, to_d;
  logic           load, done;
  logic           wd_enable, wd_expired;

  assign req      = {endgame_req, whistle_req};
  assign pend_now = pend_q | req;
  assign data     = data_q;

  assign live_snap = '{ball_posx:  ball_posx,
                       ball_posy:  ball_posy,
                       pl_posx:    pl_posx,
                       pl_posy:    pl_posy,
                       score_pl1:  score_pl1,
                       score_pl2:  score_pl2,
                       last_touch: last_touch};

  assign wd_enable = (state_q == ST_WAIT_DONE);

  uart_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk65MHz),
    .rst     (rst),
    .enable  (wd_enable),
    .clear   (!wd_enable),
    .expired (wd_expired)
  );

  // Next-state and registered-output logic; every word boundary funnels through load.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    evt_d   = evt_q;
    pend_d  = pend_now;
    dv_d    = data_valid;
    ov_d    = frame_tick && (state_q != ST_IDLE);
    to_d    = 1'b0;
    load    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick || (|pend_now)) begin
          if (frame_tick) begin
            snap_d  = live_snap;
            frame_d = 1'b1;
            idx_d   = '0;
          end
          load = 1'b1;
        end
      end
      ST_SEND: begin
        if (conv16to8ready && data_valid) begin
          state_d = ST_WAIT_DONE;
          dv_d    = 1'b0;
          // Only the bits carried by the accepted word are retired; a same-cycle request re-arms.
          if (evt_q) begin
            pend_d = (pend_q & ~data_q.payload[1:0]) | req;
          end
        end
      end
      ST_WAIT_DONE: begin
        done = tx_done || wd_expired;
        to_d = wd_expired && !tx_done;
        if (done) begin
          if (!evt_q) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              frame_d = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          if (frame_d || (|pend_now)) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending events pre-empt the next state word.
    if (load) begin
      state_d = ST_SEND;
      dv_d    = 1'b1;
      if (|pend_now) begin
        data_d = event_word(pend_now[1], pend_now[0]);
        evt_d  = 1'b1;
      end else begin
        data_d = state_word(snap_d, idx_d);
        evt_d  = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      frame_q    <= 1'b0;
      evt_q      <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      evt_q      <= evt_d;
      data_valid <= dv_d;
      busy       <= busy_d;
      overrun    <= ov_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: table-driven frames, directed corner sequences,
// and a randomized run checked against a word-count level reference model.
module tb_uart_tx_scheduler;

  localparam int unsigned TO_CYC = 100;

  logic        clk65MHz = 1'b0;
  logic        rst = 1'b0, frame_tick = 1'b0;
  logic [11:0] ball_posx = '0, ball_posy = '0, pl_posx = '0, pl_posy = '0;
  logic [3:0]  score_pl1 = '0, score_pl2 = '0;
  logic        last_touch = 1'b0, whistle_req = 1'b0, endgame_req = 1'b0;
  logic        conv16to8ready = 1'b1, tx_done = 1'b0;
  logic [15:0] data;
  logic        data_valid, busy, overrun, timeout;

  always #5 clk65MHz = ~clk65MHz;

  uart_tx_scheduler #(.TIMEOUT_CYCLES(TO_CYC), .FRAME_WORDS(6)) dut (
    .clk65MHz(clk65MHz), .rst(rst), .frame_tick(frame_tick),
    .ball_posx(ball_posx), .ball_posy(ball_posy), .pl_posx(pl_posx), .pl_posy(pl_posy),
    .score_pl1(score_pl1), .score_pl2(score_pl2), .last_touch(last_touch),
    .whistle_req(whistle_req), .endgame_req(endgame_req),
    .conv16to8ready(conv16to8ready), .tx_done(tx_done),
    .data(data), .data_valid(data_valid), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  typedef struct packed {
    logic [11:0] bx, by, px, py;
    logic [3:0]  s1, s2;
    logic        lt;
    logic [5:0][15:0] w;
  } vec_t;

  vec_t vecs [4];

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  int tx_cnt = 0, tx_delay = 10, rdy_mode = 0;
  int acc_cyc = 0, ov_hi = 0, to_hi = 0, to_cyc = 0, stab_err = 0;
  logic rand_delay = 1'b0, model_on = 1'b0;
  int exp_total = 0, dones = 0, exp_ov = 0;

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, g, e);
    end
  endtask

  // Reference frame from the live inputs, straight from the word-format rules.
  function automatic logic [95:0] frame_words();
    return {4'h1, ball_posx, 4'h2, ball_posy, 4'h3, pl_posx, 4'h4, pl_posy,
            4'h5, 4'h0, score_pl1, score_pl2, 4'h6, 11'h0, last_touch};
  endfunction

  function automatic logic [15:0] got_at(input int j);
    if (j < got.size()) return got[j];
    return 16'hxxxx;
  endfunction

  // One clock: serializer model, monitors and reference model all advance here.
  task automatic step();
    logic acc, dv_pre, ft_pre, td_pre, rst_pre, m_idle;
    logic [15:0] d_pre;
    logic [95:0] fw;
    acc     = data_valid && conv16to8ready && !rst;
    dv_pre  = data_valid;
    d_pre   = data;
    ft_pre  = frame_tick;
    td_pre  = tx_done;
    rst_pre = rst;
    m_idle  = (exp_total == dones);
    fw      = frame_words();
    @(posedge clk65MHz);
    #1;
    cyc++;
    if (dv_pre === 1'b1 && !acc && !rst_pre && (data_valid !== 1'b1 || data !== d_pre)) stab_err++;
    tx_done = 1'b0;
    if (tx_cnt > 0) tx_cnt--;
    if (acc === 1'b1) begin
      got.push_back(d_pre);
      acc_cyc = cyc;
      tx_cnt  = rand_delay ? int'($urandom_range(1, 12)) : tx_delay;
    end
    if (tx_cnt == 1) tx_done = 1'b1;
    if (overrun === 1'b1) ov_hi++;
    if (timeout === 1'b1) begin
      to_hi++;
      to_cyc = cyc - acc_cyc;
    end
    if (model_on) begin
      if (ft_pre) begin
        if (m_idle) begin
          for (int i = 0; i < 6; i++) exp_q.push_back(fw[95-16*i -: 16]);
          exp_total += 6;
        end else begin
          exp_ov++;
        end
      end
      if (td_pre) dones++;
    end
    case (rdy_mode)
      0:       conv16to8ready = 1'b1;
      1:       conv16to8ready = ($urandom_range(0, 3) != 0);
      default: conv16to8ready = 1'b0;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    if (got.size() < n) check("wait_words", got.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    if (busy !== 1'b0) check("wait_idle", busy, 0);
  endtask

  task automatic set_vec(input int i, input logic [11:0] bx, by, px, py, input logic [3:0] s1, s2,
                         input logic lt, input logic [15:0] w0, w1, w2, w3, w4, w5);
    vecs[i].bx = bx; vecs[i].by = by; vecs[i].px = px; vecs[i].py = py;
    vecs[i].s1 = s1; vecs[i].s2 = s2; vecs[i].lt = lt;
    vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2;
    vecs[i].w[3] = w3; vecs[i].w[4] = w4; vecs[i].w[5] = w5;
  endtask

  task automatic drive_vec(input int i);
    ball_posx = vecs[i].bx; ball_posy = vecs[i].by; pl_posx = vecs[i].px; pl_posy = vecs[i].py;
    score_pl1 = vecs[i].s1; score_pl2 = vecs[i].s2; last_touch = vecs[i].lt;
  endtask

  task automatic rand_live();
    ball_posx = 12'($urandom); ball_posy = 12'($urandom);
    pl_posx = 12'($urandom); pl_posy = 12'($urandom);
    score_pl1 = 4'($urandom); score_pl2 = 4'($urandom); last_touch = 1'($urandom);
  endtask

  // Start a frame from table entry i, then scramble live inputs to prove the snapshot.
  task automatic tick_vec(input int i);
    drive_vec(i);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    rand_live();
  endtask

  task automatic check_seq(input string name, input logic [15:0] e [$]);
    check({name, "_count"}, got.size(), e.size());
    for (int j = 0; j < e.size(); j++) check($sformatf("%s_w%0d", name, j), got_at(j), e[j]);
  endtask

  task automatic check_vec(input string name, input int i);
    logic [15:0] e [$];
    for (int j = 0; j < 6; j++) e.push_back(vecs[i].w[j]);
    check_seq(name, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] e [$];
    int mism, k;

    set_vec(0, 12'h123, 12'h456, 12'h0AB, 12'h0CD, 4'd3, 4'd7, 1'b1,
            16'h1123, 16'h2456, 16'h30AB, 16'h40CD, 16'h5037, 16'h6001);
    set_vec(1, 12'hFFF, 12'h000, 12'h800, 12'h7FF, 4'hF, 4'h0, 1'b0,
            16'h1FFF, 16'h2000, 16'h3800, 16'h47FF, 16'h50F0, 16'h6000);
    set_vec(2, 12'h000, 12'hFFF, 12'h001, 12'hFFE, 4'h0, 4'hF, 1'b1,
            16'h1000, 16'h2FFF, 16'h3001, 16'h4FFE, 16'h500F, 16'h6001);
    set_vec(3, 12'hA5A, 12'h5A5, 12'h3C3, 12'hC3C, 4'h9, 4'h6, 1'b0,
            16'h1A5A, 16'h25A5, 16'h33C3, 16'h4C3C, 16'h5096, 16'h6000);

    rst = 1'b1;
    steps(2);
    check("rst_data", data, 16'h0000);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    steps(2);

    // Table-driven frames, ready every cycle.
    for (int i = 0; i < 4; i++) begin
      got.delete();
      tx_delay = (i == 0) ? 10 : 3;
      tick_vec(i);
      if (i == 0) begin
        check("first_valid", data_valid, 1);
        check("first_word", data, 16'h1123);
        check("first_busy", busy, 1);
      end
      wait_words(6, 400);
      wait_idle(100);
      check_vec($sformatf("vec%0d", i), i);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
    end

    // Whistle during word 2 in flight.
    got.delete();
    tx_delay = 10;
    tick_vec(0);
    wait_words(2, 100);
    whistle_req = 1'b1;
    step();
    whistle_req = 1'b0;
    wait_words(7, 400);
    wait_idle(100);
    e = '{16'h1123, 16'h2456, 16'hE001, 16'h30AB, 16'h40CD, 16'h5037, 16'h6001};
    check_seq("evt_prio", e);

    // Request coinciding with event-word accept keeps its bit.
    got.delete();
    tick_vec(0);
    wait_words(1, 100);
    whistle_req = 1'b1;
    step();
    whistle_req = 1'b0;
    k = 0;
    while (!(data_valid === 1'b1 && data === 16'hE001) && k < 100) begin
      step();
      k++;
    end
    whistle_req = 1'b1;
    step();
    whistle_req = 1'b0;
    wait_words(8, 400);
    wait_idle(100);
    e = '{16'h1123, 16'hE001, 16'hE001, 16'h2456, 16'h30AB, 16'h40CD, 16'h5037, 16'h6001};
    check_seq("set_wins", e);

    // Event-only transfer returns to idle.
    got.delete();
    endgame_req = 1'b1;
    step();
    endgame_req = 1'b0;
    wait_words(1, 50);
    wait_idle(100);
    steps(15);
    e = '{16'hE002};
    check_seq("evt_only", e);
    check("evt_only_busy", busy, 0);

    // Second frame_tick mid-frame is dropped.
    got.delete();
    ov_hi = 0;
    tick_vec(1);
    wait_words(2, 100);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_words(6, 400);
    wait_idle(100);
    steps(20);
    check("overrun_pulses", ov_hi, 1);
    check_vec("overrun_frame", 1);

    // Serializer backpressure holds the word.
    got.delete();
    stab_err = 0;
    rdy_mode = 2;
    conv16to8ready = 1'b0;
    tick_vec(2);
    steps(20);
    check("bp_valid", data_valid, 1);
    check("bp_data", data, 16'h1000);
    check("bp_nothing_accepted", got.size(), 0);
    rdy_mode = 0;
    conv16to8ready = 1'b1;
    step();
    check("bp_first_ready_accept", got.size(), 1);
    wait_words(6, 400);
    wait_idle(100);
    check_vec("bp_frame", 2);

    // tx_done outside WAIT_DONE is ignored.
    got.delete();
    tx_done = 1'b1;
    step();
    check("spur_idle_busy", busy, 0);
    check("spur_idle_valid", data_valid, 0);
    rdy_mode = 2;
    conv16to8ready = 1'b0;
    tick_vec(3);
    tx_done = 1'b1;
    step();
    check("spur_send_valid", data_valid, 1);
    check("spur_send_data", data, 16'h1A5A);
    rdy_mode = 0;
    conv16to8ready = 1'b1;
    wait_words(6, 400);
    wait_idle(100);
    check_vec("spur_frame", 3);
    check("no_timeout_so_far", to_hi, 0);
    check("stable_while_held", stab_err, 0);

    // Watchdog: first word never gets tx_done.
    got.delete();
    to_hi = 0;
    tx_delay = 0;
    tick_vec(0);
    wait_words(1, 50);
    tx_delay = 3;
    k = 0;
    while (to_hi == 0 && k < 300) begin
      step();
      k++;
    end
    check("timeout_cycle", to_cyc, TO_CYC);
    wait_words(6, 400);
    wait_idle(100);
    check("timeout_pulses", to_hi, 1);
    check_vec("timeout_frame", 0);

    // Reset during word 3 with an event pending.
    got.delete();
    tx_delay = 10;
    tick_vec(0);
    wait_words(3, 100);
    whistle_req = 1'b1;
    step();
    whistle_req = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_data", data, 16'h0000);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flags", {overrun, timeout}, 0);
    rst = 1'b0;
    tx_cnt = 0;
    tx_done = 1'b0;
    k = got.size();
    steps(10);
    check("post_rst_no_words", got.size(), k);
    check("post_rst_valid", data_valid, 0);
    check("post_rst_busy", busy, 0);
    got.delete();
    tick_vec(0);
    check("restart_word", data, 16'h1123);
    wait_words(6, 400);
    wait_idle(100);
    check_vec("restart_frame", 0);

    // Randomized run against the reference model.
    got.delete();
    exp_q.delete();
    exp_total = 0;
    dones = 0;
    exp_ov = 0;
    ov_hi = 0;
    to_hi = 0;
    model_on = 1'b1;
    rand_delay = 1'b1;
    rdy_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      rand_live();
      frame_tick = ($urandom_range(0, 39) == 0);
      step();
    end
    frame_tick = 1'b0;
    k = 0;
    while (!(dones == exp_total && busy === 1'b0) && k < 3000) begin
      step();
      k++;
    end
    steps(3);
    model_on = 1'b0;
    check("rand_word_count", got.size(), exp_q.size());
    mism = 0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (got_at(j) !== exp_q[j]) begin
        if (mism == 0) $display("FAIL rand_word%0d: got %h expected %h", j, got_at(j), exp_q[j]);
        mism++;
      end
    end
    check("rand_word_mismatches", mism, 0);
    check("rand_overruns", ov_hi, exp_ov);
    check("rand_no_timeout", to_hi, 0);
    check("rand_busy_end", busy, 0);
    check("stable_overall", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameters, one per line:
  - TIMEOUT_CYCLES, 65000: max cycles to wait for tx_done after word accept.
  - FRAME_WORDS, 6: state words per frame (fixed; for documentation/checking).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high; clock port clk65MHz, reset port rst.
REQ-003 Ports, one per line (name, direction, width, meaning):
  - clk65MHz  in  1  system clock.
  - rst  in  1  sync active-high reset.
  - frame_tick  in  1  one-cycle pulse requesting a state frame.
  - ball_posx, ball_posy  in  12 each  ball position.
  - pl_posx, pl_posy  in  12 each  local player position.
  - score_pl1, score_pl2  in  4 each  scores.
  - last_touch  in  1  point flag.
  - whistle_req, endgame_req  in  1 each  event request pulses.
  - conv16to8ready  in  1  serializer accepts word this cycle.
  - tx_done  in  1  pulse, word fully transmitted.
  - data  out  16  word to serializer.
  - data_valid  out  1  data is valid.
  - busy  out  1  frame or event in progress.
  - overrun  out  1  one-cycle pulse, frame_tick dropped.
  - timeout  out  1  one-cycle pulse, tx_done watchdog expired.

Function
REQ-004 Word format SHALL be {tag[3:0], payload[11:0]}; state words in order:
  - index 0: tag 1, ball_posx.
  - index 1: tag 2, ball_posy.
  - index 2: tag 3, pl_posx.
  - index 3: tag 4, pl_posy.
  - index 4: tag 5, {4'b0, score_pl1, score_pl2}.
  - index 5: tag 6, {11'b0, last_touch}.
REQ-005 Event word SHALL be {4'hE, 10'b0, endgame, whistle}, built from the pending bits.
REQ-006 On frame_tick in IDLE, all state inputs SHALL be snapshotted that cycle; the frame SHALL send the snapshot, not live inputs.
REQ-007 FSM states SHALL be IDLE, SEND, WAIT_DONE.
  - IDLE -> SEND when frame_tick or any pending event; data_valid asserted the next cycle.
  - SEND -> WAIT_DONE on conv16to8ready && data_valid (accept).
  - WAIT_DONE -> SEND (next word) or IDLE (last word, no pending event) on tx_done.
REQ-008 data and data_valid SHALL stay stable in SEND until accepted.
REQ-009 Event requests SHALL set sticky pending bits; at each word boundary (entry to SEND), a pending event word SHALL be sent before the next state word.
REQ-010 Pending bits SHALL clear on event-word accept; a request in the same cycle as accept SHALL keep its bit set (set wins).
REQ-011 Events may be sent outside a frame; after an event-only transfer the FSM SHALL return to IDLE.
REQ-012 frame_tick while busy SHALL be dropped and SHALL pulse overrun for one cycle; the snapshot SHALL be unchanged.
REQ-013 The word index SHALL count 0..5; after index 5 is done the frame ends and the index resets to 0.
REQ-014 The watchdog SHALL count cycles in WAIT_DONE; at TIMEOUT_CYCLES without tx_done:
  - pulse timeout;
  - treat as done and advance as if tx_done occurred.
REQ-015 A tx_done in any state other than WAIT_DONE SHALL be ignored.
REQ-016 busy SHALL be high in SEND and WAIT_DONE, low in IDLE.

Reset
REQ-017 rst SHALL force, on the next edge:
  - FSM to IDLE;
  - data = 16'h0000, data_valid = 0;
  - busy, overrun, timeout = 0;
  - pending bits, index and watchdog cleared.
REQ-018 Reset mid-transfer SHALL abandon the word with no further data_valid; the serializer is reset by the same rst.

Structure
REQ-019 Tag constants (1..6, E) and the FSM state encoding SHALL live in a shared package uart_pkg, also used by the receive-side demultiplexer.
REQ-020 The watchdog SHALL be a sub-module uart_watchdog (inputs: enable, clear; output: expired); everything else is flat.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
  - Frame order: ball_posx=12'h123, ball_posy=12'h456, pl_posx=12'h0AB, pl_posy=12'h0CD, scores 3/7, last_touch=1; frame_tick; serializer ready every cycle; tx_done 10 cycles after accept -> words 1123, 2456, 30AB, 40CD, 5037, 6001 in order; busy low after the last.
  - Event priority: whistle_req during word 2 WAIT_DONE -> next word E001, then 30AB continues.
  - Overrun: second frame_tick mid-frame -> overrun pulse one cycle; exactly 6 state words sent.
  - Backpressure: conv16to8ready low 20 cycles -> data and data_valid held stable; word accepted on the first ready cycle.
  - Timeout: TIMEOUT_CYCLES=100, no tx_done -> timeout pulse at cycle 100; next word follows.
  - Reset mid-frame: rst during word 3 -> all outputs zero next cycle; IDLE; new frame_tick restarts at tag 1.
